// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, FETCH, WAIT, HOLD} fetch_state_t;

    typedef enum logic [1:0] {REDIR_NONE, REDIR_JMP, REDIR_BR, REDIR_EXC} redir_src_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES   = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0380;

    function automatic logic [31:0] next_pc(input logic [31:0] p);
        return p + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding buffer for a fetched slot that arrived while downstream was stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t wr_ent,
    output logic         full,
    output fetch_entry_t rd_ent
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            rd_ent <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full   <= 1'b1;
            rd_ent <= wr_ent;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and imem request/ack sequencer with skid buffer, redirect squash and registered IF output.
// Define MISALIGN_CHK_EN to fetch misaligned redirect targets as address-error slots on if_adel.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
`ifdef MISALIGN_CHK_EN
    output logic        if_adel,
`endif
    output logic [31:0] pc
);

    fetch_state_t state, state_nxt;
    redir_src_t   src;
    logic [31:0]  tgt, pc_nxt;
    logic         redir, squash, squash_nxt, misalign;
    logic         dlv, buf_load, buf_unload, buf_clear, buf_full, if_vld;
    fetch_entry_t dlv_ent, buf_ent, if_ent;

    always_comb begin
        if (exc)           src = REDIR_EXC;
        else if (br_taken) src = REDIR_BR;
        else if (jmp)      src = REDIR_JMP;
        else               src = REDIR_NONE;
        redir = (src != REDIR_NONE);
        case (src)
            REDIR_EXC: tgt = EXC_VEC;
            REDIR_BR:  tgt = br_target;
            default:   tgt = jmp_target;
        endcase
`ifndef MISALIGN_CHK_EN
        tgt[1:0] = 2'b00;
`endif
    end

`ifdef MISALIGN_CHK_EN
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        squash_nxt = squash;
        imem_req   = 1'b0;
        dlv        = 1'b0;
        dlv_ent    = '{inst: imem_rdata, pc: pc, adel: 1'b0};
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                imem_req = !stall && !misalign;
                if (misalign && !stall) begin
                    // misaligned slot never touches memory; it is delivered as an address error
                    dlv     = 1'b1;
                    dlv_ent = '{inst: 32'h0, pc: pc, adel: 1'b1};
                    pc_nxt  = next_pc(pc);
                end else if (imem_req) begin
                    if (imem_ack) begin
                        dlv    = 1'b1;
                        pc_nxt = next_pc(pc);
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (squash) begin
                        squash_nxt = 1'b0;
                        state_nxt  = FETCH;
                    end else if (!stall) begin
                        dlv       = 1'b1;
                        pc_nxt    = next_pc(pc);
                        state_nxt = FETCH;
                    end else begin
                        buf_load  = 1'b1;
                        pc_nxt    = next_pc(pc);
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    buf_unload = buf_full;
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
        if (redir) begin
            pc_nxt     = tgt;
            dlv        = 1'b0;
            buf_load   = 1'b0;
            buf_unload = 1'b0;
            buf_clear  = 1'b1;
            // an issued request that has not been acked must still complete; its data is squashed
            if ((state == WAIT || (state == FETCH && imem_req)) && !imem_ack) begin
                state_nxt  = WAIT;
                squash_nxt = 1'b1;
            end else begin
                state_nxt  = FETCH;
                squash_nxt = 1'b0;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .unload (buf_unload),
        .clear  (buf_clear),
        .wr_ent (dlv_ent),
        .full   (buf_full),
        .rd_ent (buf_ent)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            squash <= 1'b0;
            if_vld <= 1'b0;
            if_ent <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            squash <= squash_nxt;
            if (dlv) begin
                if_vld <= 1'b1;
                if_ent <= dlv_ent;
            end else if (buf_unload) begin
                if_vld <= 1'b1;
                if_ent <= buf_ent;
            end else if (redir || !stall) begin
                if_vld <= 1'b0;
            end
        end
    end

    assign imem_addr = pc;
    assign if_valid  = if_vld;
    assign if_inst   = if_ent.inst;
    assign if_pc     = if_ent.pc;
`ifdef MISALIGN_CHK_EN
    assign if_adel   = if_ent.adel;
`else
    logic adel_unused;
    assign adel_unused = if_ent.adel;
`endif

endmodule
